coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Snooping MESI bus controller for a two-L1 system; drives the coherency_unit side of both caches' coherence interfaces.
- Arbitrates miss requests from the two caches and snoops the peer cache.
- Sequences peer write-back and memory fill word-by-word, then assigns the final MESI state to requester and peer.
- Sits between the L1 data caches and the shared memory bus.

Parameters:
- BLOCK_WORDS, 2, words per cache frame (power of 2, ≥1).
- N_SETS, 8, sets per cache; set index width SET_W = $clog2(N_SETS).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- req  in  [1:0]  cache i has a read or write miss pending (level, held until done[i])
- write_req  in  [1:0]  miss is a write (sampled at grant)
- req_addr  in  [1:0][31:0]  word-aligned miss address (sampled at grant)
- done  out  [1:0]  1-cycle pulse: miss served, state_transfer valid
- set_sel  out  [1:0][SET_W-1:0]  set index presented to cache i
- snoop_req  out  [1:0]  snoop strobe to cache i
- snoop_hit  in  [1:0]  cache i holds the snooped tag (valid 1 cycle after snoop_req)
- dirty  in  [1:0]  snooped frame dirty (qualified by snoop_hit)
- requested_data  in  [1:0][31:0]  word driven by cache i during write-back
- dWEN  in  [1:0]  cache i presents a write-back word
- responder_data  out  [1:0][31:0]  fill word to the requester
- fill_valid  out  [1:0]  responder_data[i] valid this cycle
- state_transfer  out  [1:0][1:0]  cc_end_state for cache i, valid with done (requester) or snoop_done (peer)
- snoop_done  out  [1:0]  1-cycle pulse: peer must adopt state_transfer
- mem_ren, mem_wen  out  1 each  memory strobes
- mem_addr  out  32  word address
- mem_wdata  out  32
- mem_rdata  in  32
- mem_ready  in  1  word transfer complete this cycle

Behaviour:
- Reset (async, RST=1): FSM=IDLE, all pulses/strobes 0, addresses/data 0, state_transfer=INVALID, RR pointer=0.
- Index math: set = req_addr[2+$clog2(BLOCK_WORDS) +: SET_W]; block base = addr with low 2+$clog2(BLOCK_WORDS) bits cleared.
- Arbitration (IDLE): if exactly one req, grant it; if both, grant the cache at the RR pointer. The pointer toggles to the other cache after each grant. Requester r, peer p=~r. Grant latches write_req/req_addr.
- Transition IDLE→SNOOP on grant.
- SNOOP (1 cycle): snoop_req[p]=1, set_sel[p]=set. Go to SNOOP_RESP.
- SNOOP_RESP (1 cycle): sample snoop_hit[p], dirty[p].
  - hit&dirty → WB.
  - else → FILL.
- WB: for each of BLOCK_WORDS words, wait dWEN[p]; then drive mem_wen=1, mem_addr=base+4k, mem_wdata=requested_data[p], held until mem_ready. The word counter k increments on mem_ready; after the last word → FILL.
- FILL: mem_ren=1, mem_addr=base+4k, held until mem_ready. On mem_ready, responder_data[r]=mem_rdata and fill_valid[r]=1 for exactly 1 cycle; k increments. After the last word → DONE.
- DONE (1 cycle): done[r]=1 and snoop_done[p]=1 (the latter only if hit), then → IDLE. No grant in the DONE cycle. Final states:
  - write miss: requester MODIFIED; peer INVALID.
  - read miss, no hit: requester EXCLUSIVE.
  - read miss, hit: requester SHARED; peer SHARED.
- Counter k is $clog2(BLOCK_WORDS) bits and wraps to 0 on leaving WB and FILL.
- Simultaneous req rising while busy: ignored until IDLE. A req dropped mid-transaction is not aborted.
- mem_ready while no strobe is asserted: ignored.
- RST mid-transaction: immediate return to IDLE; partial fill discarded, no done.
- Minimum latency with no hit and mem_ready=1 every cycle: grant→done = 3+BLOCK_WORDS cycles.

Optional Feature:
- CC_C2C_XFER_EN defined: on a clean hit (hit & !dirty), FILL sources words from the peer. It waits dWEN[p] per word and forwards requested_data[p] to responder_data[r] with no memory access. A dirty hit forwards each word to both memory and the requester in WB and skips FILL.
- Undefined: behaviour exactly as above; memory is always the fill source.

Decomposition:
- cache_coherence_pkg: cc_end_state enum, word_t, BLOCK_WORDS/N_SETS defaults, controller state enum.
- Sub-module cc_rr_arbiter: 2-way round-robin; inputs req/en; outputs grant/gnt_id; pointer updates on en&grant.

Test Plan:
- Cache0 read miss, addr 0x40, peer miss, mem_rdata 0xA0/0xA1 → two fill_valid words, done[0], state_transfer[0]=EXCLUSIVE, no snoop_done.
- Cache1 write miss 0x80, peer hit dirty, requested_data 0xDEAD/0xBEEF → mem_wen at 0x80/0x84 with those words; then fill; cache1 MODIFIED, cache0 INVALID via snoop_done[0].
- Cache0 read miss, peer clean hit → both SHARED; memory read only (macro off) or zero memory accesses (CC_C2C_XFER_EN on).
- Both req asserted at once, back-to-back → grants 0, 1, 0 alternate; no starvation over 4 misses.
- mem_ready held low 5 cycles during FILL → mem_ren and mem_addr stable, fill_valid stays 0; latency = 3+2+5.
- RST pulsed during WB → all outputs at reset values next edge; no done; a fresh req is served normally.

Source files
------------

// File: rtl/cache_coherence_pkg.sv
// rtl/cache_coherence_pkg.sv - shared MESI end-state and controller state types for coherence_bus_ctrl
package cache_coherence_pkg;

    typedef logic [31:0] word_t;

    localparam int DEF_BLOCK_WORDS = 2;
    localparam int DEF_N_SETS      = 8;

    typedef enum logic [1:0] {
        CC_INVALID   = 2'd0,
        CC_SHARED    = 2'd1,
        CC_EXCLUSIVE = 2'd2,
        CC_MODIFIED  = 2'd3
    } cc_end_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_SNOOP_RESP,
        ST_WB,
        ST_FILL,
        ST_DONE
    } cc_state_t;

endpackage

// File: rtl/cc_rr_arbiter.sv
// rtl/cc_rr_arbiter.sv - two-way round-robin arbiter; pointer moves past each granted requester
module cc_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic ptr;

    always_comb begin
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ptr;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
        grant = 2'b00;
        if (en && (req != 2'b00)) begin
            grant[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (en && (grant != 2'b00)) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - snooping MESI bus controller for two L1s; CC_C2C_XFER_EN enables cache-to-cache fill
module coherence_bus_ctrl
    import cache_coherence_pkg::*;
#(
    parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter  int N_SETS      = DEF_N_SETS,
    localparam int SET_W       = (N_SETS > 1) ? $clog2(N_SETS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            req,
    input  logic [1:0]            write_req,
    input  logic [1:0][31:0]      req_addr,
    output logic [1:0]            done,
    output logic [1:0][SET_W-1:0] set_sel,
    output logic [1:0]            snoop_req,
    input  logic [1:0]            snoop_hit,
    input  logic [1:0]            dirty,
    input  logic [1:0][31:0]      requested_data,
    input  logic [1:0]            dWEN,
    output logic [1:0][31:0]      responder_data,
    output logic [1:0]            fill_valid,
    output logic [1:0][1:0]       state_transfer,
    output logic [1:0]            snoop_done,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam int OFF_W = 2 + $clog2(BLOCK_WORDS);
    localparam int K_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST   = K_W'(BLOCK_WORDS - 1);
    localparam word_t          OFF_MASK = word_t'((64'd1 << OFF_W) - 64'd1);

    function automatic word_t word_addr(input word_t base, input logic [K_W-1:0] idx);
        return base | (word_t'(idx) << 2);
    endfunction

    cc_state_t      state;
    logic           r_id;
    logic           write_q;
    logic           hit_q;
    word_t          base_q;
    logic [K_W-1:0] k;

    logic [1:0] grant;
    logic       gnt_id;
    logic       grant_any;
    logic       p_id;
    logic       k_last;
    logic       fill_acc;
    logic       wb_last_fwd;
    logic       fin;
    word_t      fill_word;
    word_t      addr_g;

    cc_rr_arbiter u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    (req),
        .en     (state == ST_IDLE),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign grant_any = (grant != 2'b00);
    assign addr_g    = req_addr[gnt_id];
    assign p_id      = ~r_id;
    assign k_last    = (k == K_LAST);

`ifdef CC_C2C_XFER_EN
    logic c2c_q;

    // Clean hits are filled straight from the peer; dirty hits fill the requester during write-back.
    assign fill_acc    = (state == ST_FILL) && (c2c_q ? dWEN[p_id] : (mem_ren && mem_ready));
    assign fill_word   = c2c_q ? requested_data[p_id] : mem_rdata;
    assign wb_last_fwd = (state == ST_WB) && mem_wen && mem_ready && k_last;
`else
    assign fill_acc    = (state == ST_FILL) && mem_ren && mem_ready;
    assign fill_word   = mem_rdata;
    assign wb_last_fwd = 1'b0;
`endif

    assign fin = (fill_acc && k_last) || wb_last_fwd;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= ST_IDLE;
            r_id           <= 1'b0;
            write_q        <= 1'b0;
            hit_q          <= 1'b0;
            base_q         <= '0;
            k              <= '0;
            done           <= '0;
            set_sel        <= '0;
            snoop_req      <= '0;
            responder_data <= '0;
            fill_valid     <= '0;
            state_transfer <= {CC_INVALID, CC_INVALID};
            snoop_done     <= '0;
            mem_ren        <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
`ifdef CC_C2C_XFER_EN
            c2c_q          <= 1'b0;
`endif
        end else begin
            done       <= '0;
            snoop_done <= '0;
            fill_valid <= '0;
            snoop_req  <= '0;

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        r_id                <= gnt_id;
                        write_q             <= write_req[gnt_id];
                        base_q              <= addr_g & ~OFF_MASK;
                        snoop_req[~gnt_id]  <= 1'b1;
                        set_sel[~gnt_id]    <= addr_g[OFF_W +: SET_W];
                        state               <= ST_SNOOP;
                    end
                end

                ST_SNOOP: state <= ST_SNOOP_RESP;

                ST_SNOOP_RESP: begin
                    hit_q <= snoop_hit[p_id];
                    k     <= '0;
                    if (snoop_hit[p_id] && dirty[p_id]) begin
                        state <= ST_WB;
                    end else begin
                        state <= ST_FILL;
`ifdef CC_C2C_XFER_EN
                        c2c_q <= snoop_hit[p_id];
                        if (!snoop_hit[p_id]) begin
                            mem_ren  <= 1'b1;
                            mem_addr <= base_q;
                        end
`else
                        mem_ren  <= 1'b1;
                        mem_addr <= base_q;
`endif
                    end
                end

                ST_WB: begin
                    if (!mem_wen) begin
                        if (dWEN[p_id]) begin
                            mem_wen   <= 1'b1;
                            mem_addr  <= word_addr(base_q, k);
                            mem_wdata <= requested_data[p_id];
                        end
                    end else if (mem_ready) begin
                        mem_wen <= 1'b0;
`ifdef CC_C2C_XFER_EN
                        fill_valid[r_id]     <= 1'b1;
                        responder_data[r_id] <= mem_wdata;
                        c2c_q                <= 1'b0;
`endif
                        if (k_last) begin
                            k <= '0;
`ifndef CC_C2C_XFER_EN
                            state    <= ST_FILL;
                            mem_ren  <= 1'b1;
                            mem_addr <= base_q;
`endif
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (fill_acc) begin
                        fill_valid[r_id]     <= 1'b1;
                        responder_data[r_id] <= fill_word;
                        if (k_last) begin
                            k       <= '0;
                            mem_ren <= 1'b0;
                        end else begin
                            k        <= k + 1'b1;
                            mem_addr <= word_addr(base_q, k + 1'b1);
                        end
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase

            // Requester and peer learn their MESI end state together with the done pulses.
            if (fin) begin
                state            <= ST_DONE;
                done[r_id]       <= 1'b1;
                snoop_done[p_id] <= hit_q;
                state_transfer[r_id] <= write_q ? CC_MODIFIED : (hit_q ? CC_SHARED : CC_EXCLUSIVE);
                if (hit_q) begin
                    state_transfer[p_id] <= write_q ? CC_INVALID : CC_SHARED;
                end
            end
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed self-checking bench for coherence_bus_ctrl
module tb_coherence_bus_ctrl;

    logic             CLK;
    logic             RST;
    logic [1:0]       req;
    logic [1:0]       write_req;
    logic [1:0][31:0] req_addr;
    logic [1:0]       done;
    logic [1:0][2:0]  set_sel;
    logic [1:0]       snoop_req;
    logic [1:0]       snoop_hit;
    logic [1:0]       dirty;
    logic [1:0][31:0] requested_data;
    logic [1:0]       dWEN;
    logic [1:0][31:0] responder_data;
    logic [1:0]       fill_valid;
    logic [1:0][1:0]  state_transfer;
    logic [1:0]       snoop_done;
    logic             mem_ren;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ready;

    coherence_bus_ctrl #(.BLOCK_WORDS(2), .N_SETS(8)) dut (
        .CLK(CLK), .RST(RST), .req(req), .write_req(write_req), .req_addr(req_addr),
        .done(done), .set_sel(set_sel), .snoop_req(snoop_req), .snoop_hit(snoop_hit),
        .dirty(dirty), .requested_data(requested_data), .dWEN(dWEN),
        .responder_data(responder_data), .fill_valid(fill_valid),
        .state_transfer(state_transfer), .snoop_done(snoop_done), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    int          cyc, snoop_cyc, done_cyc, stall_cnt, wb_idx, n_rd, n_wr, nd;
    int          nf[2], n_done[2], n_sd[2], rereq[2], done_log[8];
    logic [31:0] wr_addr[8], wr_data[8], wb_word[2], stall_addr;
    logic [31:0] fill_data[2][8];
    logic [1:0]  done_state[2], sd_state[2];
    logic [2:0]  sel_seen;
    logic        stalling, stall_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        n_rd = 0; n_wr = 0; nd = 0; wb_idx = 0; stall_bad = 0; stalling = 0;
        snoop_cyc = 0; done_cyc = 0; sel_seen = '0;
        for (int i = 0; i < 2; i++) begin
            nf[i] = 0; n_done[i] = 0; n_sd[i] = 0; rereq[i] = 0;
            done_state[i] = '0; sd_state[i] = '0;
        end
    endtask

    // One clock of the memory, peer-cache and requester models, evaluated at the falling edge.
    task automatic cycle();
        @(negedge CLK);
        cyc++;
        mem_ready = 1'b0;
        if (!RST) begin
            if (mem_ren || mem_wen) begin
                if (stall_cnt > 0) begin
                    stall_cnt--;
                    if (mem_ren) begin
                        if (!stalling) begin
                            stall_addr = mem_addr;
                            stalling   = 1'b1;
                        end else if (mem_addr !== stall_addr) begin
                            stall_bad = 1'b1;
                        end
                        if (fill_valid != 2'b00) stall_bad = 1'b1;
                    end
                end else begin
                    mem_ready = 1'b1;
                    stalling  = 1'b0;
                    if (mem_ren) begin
                        n_rd++;
                        mem_rdata = 32'hA0 + {31'b0, mem_addr[2]};
                    end
                    if (mem_wen) begin
                        if (n_wr < 8) begin
                            wr_addr[n_wr] = mem_addr;
                            wr_data[n_wr] = mem_wdata;
                        end
                        n_wr++;
                        wb_idx++;
                        requested_data[0] = wb_word[wb_idx & 1];
                        requested_data[1] = wb_word[wb_idx & 1];
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (fill_valid[i]) begin
                    if (nf[i] < 8) fill_data[i][nf[i]] = responder_data[i];
                    nf[i]++;
                end
                if (snoop_req[i]) begin
                    snoop_cyc = cyc;
                    sel_seen  = set_sel[i];
                end
                if (done[i]) begin
                    n_done[i]++;
                    done_state[i] = state_transfer[i];
                    if (nd < 8) done_log[nd] = i;
                    nd++;
                    done_cyc = cyc;
                    if (rereq[i] > 0) rereq[i]--;
                    else req[i] = 1'b0;
                end
                if (snoop_done[i]) begin
                    n_sd[i]++;
                    sd_state[i] = state_transfer[i];
                end
            end
        end
    endtask

    task automatic wait_done(input int idx);
        for (int t = 0; t < 300 && n_done[idx] < 1; t++) cycle();
        check("done_seen", n_done[idx], 1);
        cycle();
    endtask

    task automatic set_peer(input logic [1:0] hit, input logic [1:0] drt, input logic [31:0] w0, input logic [31:0] w1);
        snoop_hit = hit; dirty = drt; dWEN = hit;
        wb_word[0] = w0; wb_word[1] = w1;
        requested_data[0] = w0; requested_data[1] = w0;
    endtask

    initial begin
        RST = 1'b1; req = '0; write_req = '0; req_addr = '0; snoop_hit = '0; dirty = '0;
        requested_data = '0; dWEN = '0; mem_rdata = '0; mem_ready = 1'b0;
        cyc = 0; stall_cnt = 0; wb_word[0] = '0; wb_word[1] = '0;
        clear_logs();
        cycle(); cycle();
        check("rst_done", {30'b0, done}, 0);
        check("rst_snoop_req", {30'b0, snoop_req}, 0);
        check("rst_mem_strobes", {30'b0, mem_ren, mem_wen}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_state_transfer", {28'b0, state_transfer}, 0);
        RST = 1'b0;
        cycle();

        // Cache0 read miss at 0x40, peer misses.
        clear_logs();
        set_peer(2'b00, 2'b00, 32'h0, 32'h0);
        write_req[0] = 1'b0; req_addr[0] = 32'h40; req[0] = 1'b1;
        wait_done(0);
        check("t1_fill_cnt", nf[0], 2);
        check("t1_fill_w0", fill_data[0][0], 32'hA0);
        check("t1_fill_w1", fill_data[0][1], 32'hA1);
        check("t1_state", {30'b0, done_state[0]}, 2);
        check("t1_no_snoop_done", n_sd[0] + n_sd[1], 0);
        check("t1_latency", done_cyc - (snoop_cyc - 1), 5);
        check("t1_no_wr", n_wr, 0);

        // Cache1 write miss at 0x80, peer0 holds it dirty.
        clear_logs();
        set_peer(2'b01, 2'b01, 32'hDEAD, 32'hBEEF);
        write_req[1] = 1'b1; req_addr[1] = 32'h80; req[1] = 1'b1;
        wait_done(1);
        check("t2_wr_cnt", n_wr, 2);
        check("t2_wr_addr0", wr_addr[0], 32'h80);
        check("t2_wr_data0", wr_data[0], 32'hDEAD);
        check("t2_wr_addr1", wr_addr[1], 32'h84);
        check("t2_wr_data1", wr_data[1], 32'hBEEF);
        check("t2_fill_cnt", nf[1], 2);
`ifdef CC_C2C_XFER_EN
        check("t2_fill_w0", fill_data[1][0], 32'hDEAD);
        check("t2_rd_cnt", n_rd, 0);
`else
        check("t2_fill_w0", fill_data[1][0], 32'hA0);
        check("t2_rd_cnt", n_rd, 2);
`endif
        check("t2_req_state", {30'b0, done_state[1]}, 3);
        check("t2_peer_sd", n_sd[0], 1);
        check("t2_peer_state", {30'b0, sd_state[0]}, 0);

        // Cache0 read miss, peer1 clean hit.
        clear_logs();
        set_peer(2'b10, 2'b00, 32'h5555, 32'h5555);
        write_req[0] = 1'b0; req_addr[0] = 32'h40; req[0] = 1'b1;
        wait_done(0);
        check("t3_req_state", {30'b0, done_state[0]}, 1);
        check("t3_peer_sd", n_sd[1], 1);
        check("t3_peer_state", {30'b0, sd_state[1]}, 1);
        check("t3_no_wr", n_wr, 0);
`ifdef CC_C2C_XFER_EN
        check("t3_rd_cnt", n_rd, 0);
`else
        check("t3_rd_cnt", n_rd, 2);
`endif

        // Cache0 read miss at 0x58 with memory stalling 5 cycles in FILL.
        clear_logs();
        set_peer(2'b00, 2'b00, 32'h0, 32'h0);
        stall_cnt = 5;
        req_addr[0] = 32'h58; req[0] = 1'b1;
        wait_done(0);
        check("t5_set_sel", {29'b0, sel_seen}, 3);
        check("t5_latency", done_cyc - (snoop_cyc - 1), 10);
        check("t5_stall_stable", {31'b0, stall_bad}, 0);
        check("t5_fill_w0", fill_data[0][0], 32'hA0);
        check("t5_fill_w1", fill_data[0][1], 32'hA1);

        // Reset while a write-back is stalled on memory, then a fresh miss.
        clear_logs();
        set_peer(2'b10, 2'b10, 32'h1111, 32'h2222);
        stall_cnt = 50;
        write_req[0] = 1'b1; req_addr[0] = 32'h100; req[0] = 1'b1;
        for (int t = 0; t < 40 && !mem_wen; t++) cycle();
        check("t6_in_wb", {31'b0, mem_wen}, 1);
        RST = 1'b1;
        #1;
        check("t6_rst_wen", {31'b0, mem_wen}, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_done", {30'b0, done}, 0);
        req = '0; stall_cnt = 0;
        set_peer(2'b00, 2'b00, 32'h0, 32'h0);
        cycle();
        RST = 1'b0;
        cycle();
        check("t6_no_done", n_done[0], 0);
        clear_logs();
        write_req[1] = 1'b0; req_addr[1] = 32'h40; req[1] = 1'b1;
        wait_done(1);
        check("t6_fresh_state", {30'b0, done_state[1]}, 2);
        check("t6_fresh_fill", nf[1], 2);

        // Both caches miss repeatedly: grants must alternate.
        clear_logs();
        write_req = 2'b00; req_addr[0] = 32'h40; req_addr[1] = 32'h40;
        rereq[0] = 1; rereq[1] = 1;
        req = 2'b11;
        for (int t = 0; t < 400 && nd < 4; t++) cycle();
        check("t4_done_cnt", nd, 4);
        check("t4_grant0", done_log[0], 0);
        check("t4_grant1", done_log[1], 1);
        check("t4_grant2", done_log[2], 0);
        check("t4_grant3", done_log[3], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
